// File: rtl/rtc_bus_responder_if.sv
// Multiplexed RTC byte bus: chip select, address/data phase flag, read and
// write strobes, the byte driven by the master and the responder's read data.
// The top level builds the physical tristate from data_out/data_oe.
interface rtc_bus_responder_if;
  logic       cs_n;
  logic       ad;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output cs_n, ad, rd_n, wr_n, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  cs_n, ad, rd_n, wr_n, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC chip model on the multiplexed CS/AD/RD/WR byte bus. Double-registers the
// bus, commits address/data on the write-strobe release, snapshots register
// data on the read-strobe fall, and keeps BCD seconds/minutes/hours on a 1 Hz
// tick. A data write and a tick in the same cycle keep the write and drop the
// tick completely.
module rtc_bus_responder (
  input  logic                        clk,
  input  logic                        reset,
  rtc_bus_responder_if.slave          bus,
  input  logic                        tick,
  output logic [7:0]                  addr_q,
  output logic                        wr_strobe
);

  localparam logic [3:0] REG_SEC  = 4'h0;
  localparam logic [3:0] REG_MIN  = 4'h1;
  localparam logic [3:0] REG_HOUR = 4'h2;

  // First and second bus register stages; edges are seen between p_* and s_*.
  logic       s_cs_n, s_ad, s_rd_n, s_wr_n;
  logic [7:0] s_data;
  logic       p_cs_n, p_ad, p_rd_n, p_wr_n;
  logic [7:0] p_data;

  logic [7:0] regs [16];
  logic [7:0] data_out_q;
  logic       data_oe_q;

  logic       wr_release;
  logic       addr_wr;
  logic       data_wr;
  logic       rd_start;
  logic       addr_hit;
  logic [7:0] rd_data;

  logic [7:0] sec_next, min_next, hour_next;
  logic       sec_carry, min_carry;

  // Seconds/minutes step: {carry, next value}. Non-BCD inputs follow the same
  // nibble rules, so e.g. 0x5A wraps to 0x00 with a carry.
  function automatic logic [8:0] inc_base60(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] r;
    logic       c;
    hi = v[7:4];
    lo = v[3:0];
    c  = 1'b0;
    if (lo >= 4'd9) begin
      if (hi >= 4'd5) begin
        r = 8'h00;
        c = 1'b1;
      end else begin
        r = {4'(hi + 4'd1), 4'h0};
      end
    end else begin
      r = {hi, 4'(lo + 4'd1)};
      if (r >= 8'h60) begin
        r = 8'h00;
        c = 1'b1;
      end
    end
    return {c, r};
  endfunction

  // Hours step in 24 h: anything at or above 0x23 wraps to midnight.
  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    logic [7:0] r;
    if (v >= 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {4'(v[7:4] + 4'd1), 4'h0};
    end else begin
      r = {v[7:4], 4'(v[3:0] + 4'd1)};
    end
    return r;
  endfunction

  // Bus decode: write release, read start and register read mux.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_release = 1'b0;
    addr_wr    = 1'b0;
    data_wr    = 1'b0;
    rd_start   = 1'b0;
    addr_hit   = 1'b0;
    rd_data    = 8'h00;

    wr_release = !p_wr_n && s_wr_n && !p_cs_n;
    addr_wr    = wr_release && !p_ad;
    data_wr    = wr_release && p_ad;
    // A low write strobe blocks the read start, so WR+RD never drives the bus.
    rd_start   = !s_cs_n && s_ad && !s_rd_n && p_rd_n && s_wr_n;
    addr_hit   = (addr_q[7:4] == 4'h0);
    if (addr_hit) begin
      rd_data = regs[addr_q[3:0]];
    end
  end

  // Timekeeping next values, chained through the seconds and minutes carries.
  always_comb begin
    sec_next  = 8'h00;
    min_next  = 8'h00;
    hour_next = 8'h00;
    sec_carry = 1'b0;
    min_carry = 1'b0;

    {sec_carry, sec_next} = inc_base60(regs[REG_SEC]);
    {min_carry, min_next} = inc_base60(regs[REG_MIN]);
    hour_next             = inc_hours(regs[REG_HOUR]);
  end

  // Two-stage input registers; reset parks them at the idle bus state so a
  // release already in flight is never seen after reset.
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      s_cs_n <= 1'b1;
      s_ad   <= 1'b1;
      s_rd_n <= 1'b1;
      s_wr_n <= 1'b1;
      s_data <= 8'h00;
      p_cs_n <= 1'b1;
      p_ad   <= 1'b1;
      p_rd_n <= 1'b1;
      p_wr_n <= 1'b1;
      p_data <= 8'h00;
    end else begin
      s_cs_n <= bus.cs_n;
      s_ad   <= bus.ad;
      s_rd_n <= bus.rd_n;
      s_wr_n <= bus.wr_n;
      s_data <= bus.data_in;
      p_cs_n <= s_cs_n;
      p_ad   <= s_ad;
      p_rd_n <= s_rd_n;
      p_wr_n <= s_wr_n;
      p_data <= s_data;
    end
  end

  // Address latch and one-cycle write strobe (also for ignored addresses).
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= 8'h00;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= data_wr;
      if (addr_wr) begin
        addr_q <= p_data;
      end
    end
  end

  // Register file: bus writes take priority and swallow a coincident tick.
  always_ff @(posedge clk) begin
    // NOTE: the register file is reset on purpose; the clock must read
    // 00:00:00 and the scratch bytes zero after every reset.
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (data_wr) begin
      if (addr_hit) begin
        regs[addr_q[3:0]] <= p_data;
      end
    end else if (tick) begin
      regs[REG_SEC] <= sec_next;
      if (sec_carry) begin
        regs[REG_MIN] <= min_next;
        if (min_carry) begin
          regs[REG_HOUR] <= hour_next;
        end
      end
    end
  end

  // Read path: snapshot on read start, drop the enable as soon as RD or CS lifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
    end else begin
      if (s_rd_n || s_cs_n) begin
        data_oe_q <= 1'b0;
      end else if (rd_start) begin
        data_oe_q <= 1'b1;
      end
      if (rd_start) begin
        data_out_q <= rd_data;
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;

endmodule
